// File: rtl/ram_loader.sv
// Streams a DEPTH-word program into the program RAM over a valid/ready byte link, holding the CPU off meanwhile.
// Define RAM_LOADER_VERIFY_EN to add a readback pass that compares a checksum of the RAM against the loaded bytes.
module ram_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  byte_valid,
    input  logic [DATA_WIDTH-1:0] byte_data,
    output logic                  byte_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    input  logic                  cpu_we,
    input  logic                  cpu_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_we,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] load_addr,
    output logic                  verify_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_VRD   = 3'd3;
    localparam logic [2:0] S_VCMP  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] byte_lat;
    logic [DATA_WIDTH-1:0] checksum;

    function automatic logic [DATA_WIDTH-1:0] wrap_add(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        return a + b;
    endfunction

`ifdef RAM_LOADER_VERIFY_EN
    logic [ADDR_WIDTH-1:0] vcnt;
    logic [DATA_WIDTH-1:0] rsum;
    logic                  verr_q;
    assign verify_err = verr_q;
`else
    logic unused_inputs;
    assign unused_inputs = ^{checksum, ram_rdata};
    assign verify_err    = 1'b0;
`endif

    // Output steering: CPU owns the RAM only while idle
    always_comb begin
        ram_addr    = cpu_addr;
        ram_data_in = cpu_data;
        ram_we      = cpu_we;
        ram_oe      = cpu_oe;
        busy        = 1'b1;
        byte_ready  = 1'b0;
        case (state)
            S_IDLE: busy = 1'b0;
            S_LOAD: begin
                ram_addr    = load_addr;
                ram_data_in = byte_lat;
                ram_we      = 1'b0;
                ram_oe      = 1'b0;
                byte_ready  = 1'b1;
            end
            S_WRITE: begin
                ram_addr    = load_addr;
                ram_data_in = byte_lat;
                ram_we      = ~abort;
                ram_oe      = 1'b0;
            end
`ifdef RAM_LOADER_VERIFY_EN
            S_VRD, S_VCMP: begin
                ram_addr    = vcnt;
                ram_data_in = byte_lat;
                ram_we      = 1'b0;
                ram_oe      = 1'b1;
            end
`endif
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            load_addr <= '0;
            done      <= 1'b0;
            byte_lat  <= '0;
            checksum  <= '0;
`ifdef RAM_LOADER_VERIFY_EN
            vcnt      <= '0;
            rsum      <= '0;
            verr_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state     <= S_LOAD;
                        load_addr <= '0;
                        done      <= 1'b0;
                        checksum  <= '0;
`ifdef RAM_LOADER_VERIFY_EN
                        verr_q    <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (byte_valid) begin
                        byte_lat <= byte_data;
                        checksum <= wrap_add(checksum, byte_data);
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (load_addr == LAST_ADDR) begin
                        load_addr <= '0;
`ifdef RAM_LOADER_VERIFY_EN
                        state     <= S_VRD;
                        vcnt      <= '0;
                        rsum      <= '0;
`else
                        state     <= S_IDLE;
                        done      <= 1'b1;
`endif
                    end else begin
                        load_addr <= load_addr + 1'b1;
                        state     <= S_LOAD;
                    end
                end
`ifdef RAM_LOADER_VERIFY_EN
                S_VRD: state <= abort ? S_IDLE : S_VCMP;
                // Read data is valid here because ram_oe has been held since VRD
                S_VCMP: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        rsum <= wrap_add(rsum, ram_rdata);
                        if (vcnt == LAST_ADDR) begin
                            state  <= S_IDLE;
                            done   <= 1'b1;
                            verr_q <= (wrap_add(rsum, ram_rdata) != checksum);
                        end else begin
                            vcnt  <= vcnt + 1'b1;
                            state <= S_VRD;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a behavioural 16x8 RAM and a write scoreboard.
module tb_ram_loader;
    logic       clk = 1'b0;
    logic       reset, start, abort, byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_data;
    logic       cpu_we, cpu_oe;
    logic [3:0] ram_addr;
    logic [7:0] ram_data_in;
    logic       ram_we, ram_oe;
    logic [7:0] ram_rdata = 8'h00;
    logic       busy, done, verify_err;
    logic [3:0] load_addr;

    logic [7:0]  mem [16];
    logic        corrupt = 1'b0;
    logic [11:0] exp_q [$];
    logic [11:0] exp_w;
    int checks = 0;
    int errors = 0;

`ifdef RAM_LOADER_VERIFY_EN
    localparam int LOAD_EDGES = 64;
`else
    localparam int LOAD_EDGES = 32;
`endif

    ram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_we(cpu_we), .cpu_oe(cpu_oe),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_rdata(ram_rdata), .busy(busy), .done(done), .load_addr(load_addr),
        .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, read data one edge after oe
    always @(posedge clk) begin
        if (ram_we === 1'b1) mem[ram_addr] <= ram_data_in;
        if (ram_oe === 1'b1)
            ram_rdata <= (corrupt && ram_addr == 4'd4) ? 8'hFF : mem[ram_addr];
        else
            ram_rdata <= 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", {20'h0, ram_addr, ram_data_in}, 32'hFFFF_FFFF);
            end else begin
                exp_w = exp_q.pop_front();
                check("ram_write", {20'h0, ram_addr, ram_data_in}, {20'h0, exp_w});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(output int cnt);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
    endtask

    task automatic feed_one(input logic [7:0] d, input logic [3:0] a, input bit wr, inout int cnt);
        int w;
        w = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        @(negedge clk);
        while (byte_ready !== 1'b1 && w < 8) begin
            tick(); cnt++; w++;
            @(negedge clk);
        end
        if (w == 8) check("ready_timeout", {31'h0, byte_ready}, 32'd1);
        if (wr) exp_q.push_back({a, d});
        tick(); cnt++;
    endtask

    task automatic wait_done(inout int cnt);
        int w;
        w = 0;
        @(negedge clk);
        while (done !== 1'b1 && w < 200) begin
            tick(); cnt++; w++;
            @(negedge clk);
        end
        if (w == 200) check("done_timeout", {31'h0, done}, 32'd1);
    endtask

    task automatic run_load(input logic [7:0] base, input int gap_idx, input int gap_len,
                            output int edges);
        int cnt;
        do_start(cnt);
        for (int i = 0; i < 16; i++) begin
            if (i == gap_idx) begin
                byte_valid = 1'b0;
                tick(); cnt++;
                for (int g = 0; g < gap_len; g++) begin
                    if (g == 1) start = 1'b1;
                    @(negedge clk);
                    check("gap_ready", {31'h0, byte_ready}, 32'd1);
                    tick(); cnt++;
                    start = 1'b0;
                end
                check("start_ignored_addr", {28'h0, load_addr}, i);
            end
            feed_one(base + 8'(i), 4'(i), 1'b1, cnt);
        end
        byte_valid = 1'b0;
        wait_done(cnt);
        edges = cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int edges;
        int cnt;
        reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        cpu_addr = 4'd0; cpu_data = 8'h00; cpu_we = 1'b0; cpu_oe = 1'b0;
        #1;
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_ready", {31'h0, byte_ready}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_load_addr", {28'h0, load_addr}, 32'd0);
        check("rst_verify_err", {31'h0, verify_err}, 32'd0);
        tick();
        reset = 1'b0;

        // Idle pass-through write
        cpu_addr = 4'd3; cpu_data = 8'hA5; cpu_we = 1'b1;
        exp_q.push_back({4'd3, 8'hA5});
        @(negedge clk);
        check("pt_addr", {28'h0, ram_addr}, 32'd3);
        tick();
        cpu_we = 1'b0; cpu_oe = 1'b1;
        @(negedge clk);
        check("pt_mem3", {24'h0, mem[3]}, 32'hA5);
        check("pt_oe", {31'h0, ram_oe}, 32'd1);
        cpu_oe = 1'b0;

        // Reset in the middle of a load, with load_addr at 5
        do_start(cnt);
        for (int i = 0; i < 5; i++) feed_one(8'h40 + 8'(i), 4'(i), 1'b1, cnt);
        byte_valid = 1'b0;
        tick();
        @(negedge clk);
        check("mid_load_addr", {28'h0, load_addr}, 32'd5);
        check("mid_busy", {31'h0, busy}, 32'd1);
        cpu_addr = 4'd3; cpu_oe = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("arst_busy", {31'h0, busy}, 32'd0);
        check("arst_ready", {31'h0, byte_ready}, 32'd0);
        check("arst_load_addr", {28'h0, load_addr}, 32'd0);
        check("arst_done", {31'h0, done}, 32'd0);
        check("arst_pt_addr", {28'h0, ram_addr}, 32'd3);
        check("arst_pt_oe", {31'h0, ram_oe}, 32'd1);
        #2 reset = 1'b0;
        cpu_oe = 1'b0;

        // Back-to-back load of 0x10..0x1F
        run_load(8'h10, -1, 0, edges);
        check("full_edges", edges, LOAD_EDGES);
        check("full_done", {31'h0, done}, 32'd1);
        check("full_load_addr", {28'h0, load_addr}, 32'd0);
        check("full_mem7", {24'h0, mem[7]}, 32'h17);
        check("full_mem15", {24'h0, mem[15]}, 32'h1F);
        check("full_verify_err", {31'h0, verify_err}, 32'd0);

        // Same load with a 5-cycle stall before byte 3 and a start pulse during it
        run_load(8'h10, 3, 5, edges);
        check("gap_edges", edges, LOAD_EDGES + 5);
        check("gap_done", {31'h0, done}, 32'd1);
        for (int i = 0; i < 16; i++) check("gap_mem", {24'h0, mem[i]}, 32'h10 + i);

        // Abort during the WRITE cycle of address 9
        do_start(cnt);
        for (int i = 0; i < 9; i++) feed_one(8'h60 + 8'(i), 4'(i), 1'b1, cnt);
        feed_one(8'h69, 4'd9, 1'b0, cnt);
        byte_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        check("abort_we", {31'h0, ram_we}, 32'd0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_done", {31'h0, done}, 32'd0);
        check("abort_mem9", {24'h0, mem[9]}, 32'h19);
        check("abort_mem8", {24'h0, mem[8]}, 32'h68);

        // start and abort together while idle: abort wins
        tick();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", {31'h0, busy}, 32'd0);

`ifdef RAM_LOADER_VERIFY_EN
        run_load(8'h00, -1, 0, edges);
        check("ver_ok_edges", edges, 64);
        check("ver_ok_done", {31'h0, done}, 32'd1);
        check("ver_ok_err", {31'h0, verify_err}, 32'd0);
        corrupt = 1'b1;
        run_load(8'h00, -1, 0, edges);
        corrupt = 1'b0;
        check("ver_bad_edges", edges, 64);
        check("ver_bad_done", {31'h0, done}, 32'd1);
        check("ver_bad_err", {31'h0, verify_err}, 32'd1);
`endif

        tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
